// File: rtl/interval_timer.sv
// Interval timer: loads a duration from the time-parameter store after a short
// settling wait, counts it down on one-second ticks and pulses expired at the end.
module interval_timer #(
    parameter int unsigned LOAD_WAIT = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval_in,
    input  logic       hold,
    input  logic       one_hz_enable,
    input  logic [3:0] value,
    output logic [1:0] interval,
    output logic [3:0] remaining,
    output logic       busy,
    output logic       expired
);

    localparam int unsigned WAIT_W = 2;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOAD_WAIT - 1);
    localparam logic [1:0] ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COUNT,
        EXPIRE
    } state_t;

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;

    // busy/expired are registered alongside state so they always mirror it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            interval  <= 2'b00;
            remaining <= 4'd0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
        end else if (start_timer && (interval_in != ILLEGAL)) begin
            state    <= WAIT;
            interval <= interval_in;
            wait_cnt <= '0;
            busy     <= 1'b1;
            expired  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    remaining <= 4'd0;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        remaining <= value;
                        wait_cnt  <= '0;
                        if (value != 4'd0) begin
                            state <= COUNT;
                        end else begin
                            state   <= EXPIRE;
                            expired <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                COUNT: begin
                    if (one_hz_enable && !hold) begin
                        if (remaining > 4'd1) begin
                            remaining <= remaining - 4'd1;
                        end else begin
                            remaining <= 4'd0;
                            state     <= EXPIRE;
                            expired   <= 1'b1;
                        end
                    end
                end
                EXPIRE: begin
                    state     <= IDLE;
                    remaining <= 4'd0;
                    busy      <= 1'b0;
                    expired   <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    expired <= 1'b0;
                end
            endcase
        end
    end

endmodule
